// File: rtl/line_encoder_queue.sv
// Priority line encoder that queues every set line of a captured mask and emits one code per accepted transfer.
// Optional feature: define LINE_ENCODER_PARITY_EN to add a registered parity output over y.
module line_encoder_queue (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       load,
   input  logic [7:0] d,
   input  logic       ready,
   output logic       valid,
   output logic [2:0] y,
   output logic       busy,
   output logic [3:0] remaining,
   output logic       done,
   output logic       empty
`ifdef LINE_ENCODER_PARITY_EN
   ,
   output logic       parity
`endif
);

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   state_t     state_r, state_s;
   logic [7:0] pending_r, pending_s;
   logic [3:0] remaining_r, remaining_s;
   logic [2:0] y_r, y_s;
   logic       valid_r, valid_s;
   logic       busy_r, busy_s;
   logic       done_r, done_s;
   logic       empty_r, empty_s;
   logic       xfer_s;
   logic [7:0] rest_s;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] cnt;
      cnt = 4'd0;
      for (int i = 0; i < 8; i++) begin
         cnt = cnt + {3'b000, v[i]};
      end
      return cnt;
   endfunction

   // Scans upward so the highest set bit wins; bit i maps to code 7-i.
   function automatic logic [2:0] encode8(input logic [7:0] v);
      logic [2:0] code;
      code = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) begin
            code = 3'd7 - i[2:0];
         end else begin
            code = code;
         end
      end
      return code;
   endfunction

   function automatic logic [7:0] code_mask(input logic [2:0] c);
      return 8'b1000_0000 >> c;
   endfunction

   function automatic logic parity3(input logic [2:0] v);
      return ^v;
   endfunction

   assign xfer_s = (state_r == PRESENT) && valid_r && ready && enable;
   assign rest_s = pending_r & ~code_mask(y_r);

   // Next-state and next-output computation.
   always_comb begin
      state_s     = state_r;
      pending_s   = pending_r;
      remaining_s = remaining_r;
      y_s         = y_r;
      valid_s     = 1'b0;
      done_s      = 1'b0;
      empty_s     = 1'b0;
      if (!enable) begin
         state_s = state_r;
      end else begin
         case (state_r)
            IDLE: begin
               if (load && (d != 8'h00)) begin
                  state_s     = PRESENT;
                  pending_s   = d;
                  remaining_s = popcount8(d);
                  y_s         = encode8(d);
                  valid_s     = 1'b1;
               end else if (load) begin
                  empty_s = 1'b1;
               end else begin
                  state_s = IDLE;
               end
            end
            PRESENT: begin
               valid_s = 1'b1;
               if (xfer_s) begin
                  pending_s   = rest_s;
                  remaining_s = remaining_r - 4'd1;
                  if (rest_s == 8'h00) begin
                     state_s = IDLE;
                     valid_s = 1'b0;
                     done_s  = 1'b1;
                  end else begin
                     y_s = encode8(rest_s);
                  end
               end else begin
                  pending_s = pending_r;
               end
            end
            default: begin
               state_s = IDLE;
            end
         endcase
      end
      busy_s = (state_s == PRESENT);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         pending_r   <= 8'h00;
         remaining_r <= 4'd0;
         y_r         <= 3'd0;
         valid_r     <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         empty_r     <= 1'b0;
      end else begin
         state_r     <= state_s;
         pending_r   <= pending_s;
         remaining_r <= remaining_s;
         y_r         <= y_s;
         valid_r     <= valid_s;
         busy_r      <= busy_s;
         done_r      <= done_s;
         empty_r     <= empty_s;
      end
   end

`ifdef LINE_ENCODER_PARITY_EN
   logic parity_r;

   // Parity tracks y on the same edge it is loaded.
   always_ff @(posedge clk) begin
      if (rst) begin
         parity_r <= 1'b0;
      end else begin
         parity_r <= parity3(y_s);
      end
   end

   assign parity = parity_r;
`endif

   assign valid     = valid_r;
   assign y         = y_r;
   assign busy      = busy_r;
   assign remaining = remaining_r;
   assign done      = done_r;
   assign empty     = empty_r;

endmodule
